uart_tx_arbiter: RTL

Shares one UART transmitter between N_REQ byte producers (debug console, status reporter, etc.). Round-robin arbitration per byte. Drives the transmitter's write-enable/byte inputs and times each frame internally, because the transmitter exposes no busy flag. Sits directly in front of the transmitter; its outputs connect to the transmitter's wen/byte ports.

---
 rtl/uart_tx_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_arbiter
//  Purpose  : Shares one UART transmitter between N_REQ byte producers.
//             A round-robin choice is made per byte. The transmitter has no
//             busy flag, so the frame time is counted here.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1        system clock
//    rst        in   1        asynchronous reset, active-high
//    req_valid  in   N_REQ    requester i has a byte pending (bit i)
//    req_data   in   8*N_REQ  byte of requester i at [8i+7:8i]
//    req_ready  out  N_REQ    one-hot accept strobe (transfer on valid&ready)
//    uart_wen   out  1        one-cycle start pulse to the transmitter
//    uart_byte  out  8        byte to the transmitter, stable for the frame
//    busy       out  1        high whenever the arbiter is not idle
//    grant_id   out  GW       index of the last/current granted requester
// ============================================================================
module uart_tx_arbiter #(
    parameter  int N_REQ    = 4,
    parameter  int CLK_FREQ = 100_000_000,
    parameter  int BAUD     = 9600,
    localparam int GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   req_ready,
    output logic               uart_wen,
    output logic [7:0]         uart_byte,
    output logic               busy,
    output logic [GW-1:0]      grant_id
);

    // The transmitter holds each bit CLK_FREQ/BAUD+1 cycles. The frame is
    // start + 8 data + stop, plus two cycles of margin so a new start pulse
    // can never overlap the previous stop bit.
    localparam int unsigned c_BIT_CYCLES = CLK_FREQ / BAUD + 1;
    localparam logic [31:0] c_FRAME_LAST = 32'(10 * c_BIT_CYCLES + 2 - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [31:0]     r_cnt;
    logic [7:0]      r_byte;
    logic [GW-1:0]   r_grant;
    logic [GW-1:0]   r_ptr;

    logic            w_found;
    logic [GW-1:0]   w_winner;
    logic [GW-1:0]   w_idx;
    logic [7:0]      w_sel_byte;
    logic [GW-1:0]   w_ptr_next;
    logic            w_frame_done;

    // Round-robin search: scan ptr, ptr+1, ... wrapping modulo N_REQ and take
    // the first valid requester.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_idx    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_idx = GW'((int'(r_ptr) + k) % N_REQ);
            if (!w_found && req_valid[w_idx]) begin
                w_found  = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_sel_byte   = req_data[{w_winner, 3'b000} +: 8];
    assign w_frame_done = (r_cnt == c_FRAME_LAST);
    // Next search starts just after the requester that was served.
    assign w_ptr_next   = (r_grant == GW'(N_REQ - 1)) ? '0 : r_grant + GW'(1);

    // Accept strobe only exists in IDLE. It is also masked by rst so that a
    // requester holding valid through reset cannot see a phantom accept.
    always_comb begin
        req_ready = '0;
        if (!rst && (r_state == S_IDLE) && w_found) begin
            req_ready[w_winner] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_state_next = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_frame_done) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Datapath: byte/grant capture on acceptance, frame timer, pointer update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_byte  <= 8'h00;
            r_grant <= '0;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_byte  <= w_sel_byte;
                        r_grant <= w_winner;
                    end
                end
                S_ISSUE: begin
                    r_cnt <= '0;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_frame_done) begin
                        r_ptr <= w_ptr_next;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign uart_wen  = (r_state == S_ISSUE);
    assign busy      = (r_state != S_IDLE);
    assign uart_byte = r_byte;
    assign grant_id  = r_grant;

endmodule
`default_nettype wire
